// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 access modes, LSU FSM encoding
// and small mode-decode helpers used by the LSU and its alignment logic.
package rv32i_pkg;

    // funct3 encodings for loads/stores
    localparam logic [2:0] Funct3B  = 3'b000;
    localparam logic [2:0] Funct3H  = 3'b001;
    localparam logic [2:0] Funct3W  = 3'b010;
    localparam logic [2:0] Funct3Bu = 3'b100;
    localparam logic [2:0] Funct3Hu = 3'b101;

    typedef enum logic [1:0] {
        LsuIdle = 2'd0,
        LsuReq  = 2'd1,
        LsuWait = 2'd2,
        LsuDone = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SzByte = 2'd0,
        SzHalf = 2'd1,
        SzWord = 2'd2
    } lsu_size_e;

    // Unlisted encodings (011, 110, 111) fall through to word accesses
    function automatic lsu_size_e mode_size(input logic [2:0] mode);
        lsu_size_e sz;
        case (mode)
            Funct3B, Funct3Bu: sz = SzByte;
            Funct3H, Funct3Hu: sz = SzHalf;
            default:           sz = SzWord;
        endcase
        return sz;
    endfunction

    function automatic logic mode_unsigned(input logic [2:0] mode);
        return (mode == Funct3Bu) || (mode == Funct3Hu);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] off);
        logic mis;
        case (mode_size(mode))
            SzByte:  mis = 1'b0;
            SzHalf:  mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: byte enables and lane-replicated store
// data for the outgoing request, plus extraction/extension of returned words.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  st_mode_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_mode_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shifted;
    logic        ld_unsigned;

    // Store side: enables follow the byte offset, data is replicated across lanes
    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
        case (mode_size(st_mode_i))
            SzByte: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            SzHalf: begin
                st_be_o    = 4'b0011 << st_off_i;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: begin
                st_be_o    = 4'b1111;
                st_wdata_o = st_data_i;
            end
        endcase
    end

    // Load side: move the addressed lane to bit 0, then sign- or zero-extend
    always_comb begin
        ld_shifted  = ld_rdata_i >> {ld_off_i, 3'b000};
        ld_unsigned = mode_unsigned(ld_mode_i);
        ld_data_o   = ld_rdata_i;
        case (mode_size(ld_mode_i))
            SzByte: begin
                ld_data_o = ld_unsigned ? {24'b0, ld_shifted[7:0]}
                                        : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            end
            SzHalf: begin
                ld_data_o = ld_unsigned ? {16'b0, ld_shifted[15:0]}
                                        : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            end
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// M-stage load/store unit: turns one load/store per instruction into a single
// request/grant/response bus transaction and stalls the pipeline until done.
// Optional response timeout is enabled by defining LSU_TIMEOUT_EN.
module mem_lsu
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead_M,
    input  logic        memWrite_M,
    input  logic [2:0]  mode_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] write_Data_M,
    output logic        stall_M,
    output logic [31:0] load_data_M,
    output logic        load_valid,
    output logic        misalign_M,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    lsu_state_e  state_q, state_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [2:0]  mode_q, mode_d;
    logic [1:0]  off_q, off_d;
    logic        is_load_q, is_load_d;
    logic [31:0] load_data_q, load_data_d;

    logic        access;
    logic        misaligned;
    logic        start;
    logic        resp;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_ldata;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    lsu_align u_align (
        .st_mode_i  (mode_M),
        .st_off_i   (addr_M[1:0]),
        .st_data_i  (write_Data_M),
        .st_be_o    (align_be),
        .st_wdata_o (align_wdata),
        .ld_mode_i  (mode_q),
        .ld_off_i   (off_q),
        .ld_rdata_i (bus_rdata),
        .ld_data_o  (align_ldata)
    );

    // Request decode and combinational pipeline handshake
    always_comb begin
        access     = memRead_M | memWrite_M;
        misaligned = is_misaligned(mode_M, addr_M[1:0]);
        start      = (state_q == LsuIdle) && access && !misaligned;
        misalign_M = (state_q == LsuIdle) && access && misaligned;
        stall_M    = start || (state_q == LsuReq) || (state_q == LsuWait);
        // A response only counts once the request has been granted
        resp       = bus_rvalid && ((state_q == LsuWait) || (state_q == LsuReq && bus_gnt));
    end

    // Next-state logic for the FSM and its registered bus/result outputs
    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        we_d        = we_q;
        mode_d      = mode_q;
        off_d       = off_q;
        is_load_d   = is_load_q;
        load_data_d = load_data_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            LsuIdle: begin
                if (start) begin
                    state_d    = LsuReq;
                    bus_addr_d = {addr_M[31:2], 2'b00};
                    wdata_d    = align_wdata;
                    be_d       = align_be;
                    // Read and write together behaves as a store
                    we_d       = memWrite_M;
                    is_load_d  = memRead_M & ~memWrite_M;
                    mode_d     = mode_M;
                    off_d      = addr_M[1:0];
`ifdef LSU_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            LsuReq, LsuWait: begin
                if (resp) begin
                    state_d = LsuDone;
                    if (is_load_q) begin
                        load_data_d = align_ldata;
                    end
                end else begin
                    if (state_q == LsuReq && bus_gnt) begin
                        state_d = LsuWait;
                    end
`ifdef LSU_TIMEOUT_EN
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_d == CntW'(TIMEOUT_CYCLES)) begin
                        state_d     = LsuDone;
                        err_d       = 1'b1;
                        load_data_d = '0;
                    end
`endif
                end
            end
            LsuDone: state_d = LsuIdle;
            default: state_d = LsuIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LsuIdle;
            bus_addr_q  <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            mode_q      <= '0;
            off_q       <= '0;
            is_load_q   <= 1'b0;
            load_data_q <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            we_q        <= we_d;
            mode_q      <= mode_d;
            off_q       <= off_d;
            is_load_q   <= is_load_d;
            load_data_q <= load_data_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus_req     = (state_q == LsuReq);
    assign bus_we      = we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_be      = be_q;
    assign load_data_M = load_data_q;
    assign load_valid  = (state_q == LsuDone) && is_load_q;
`ifdef LSU_TIMEOUT_EN
    assign bus_err     = err_q;
`else
    assign bus_err     = 1'b0;
`endif

endmodule
